// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI slave register block.
package spi_slave_pkg;

  localparam int ADDR_W     = 6;
  localparam int DATA_W     = 8;
  localparam int CMD_RW_BIT = 7;
  localparam int CMD_MB_BIT = 6;
  localparam int NUM_REGS   = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    WR_DATA,
    RD_DATA
  } spiState_e;

  // Address step for multi-byte bursts; wraps naturally at the top of the map.
  function automatic logic [ADDR_W-1:0] nextAddr(input logic [ADDR_W-1:0] addr,
                                                 input logic              mb);
    return addr + {{(ADDR_W-1){1'b0}}, mb};
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with single-cycle
// rise/fall pulses aligned to the synchronized level.
module spi_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift the pin through the chain; prev_q holds the previous synchronized level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q[0] <= async_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_regs.sv
// SPI mode-3 slave with a 64 x 8 register file, oversampled on the system
// clock. Optional macro SPI_SLAVE_WRITE_EN enables SPI writes into the
// register file; without it, write transactions are shifted and discarded.
module spi_slave_regs
  import spi_slave_pkg::*;
#(
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] DEVID       = 8'hE5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_clk,
  input  logic              CS,
  input  logic              MOSI,
  output logic              MISO,
  input  logic              host_wr_en,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] last_cmd,
  output logic              cmd_valid,
  output logic              busy
);

  logic unusedSclkLvl, sclkRise, sclkFall;
  logic csLvl, csRise, csFall;
  logic mosiLvl, unusedMosiRise, unusedMosiFall;

  spiState_e         state_q, state_d;
  logic [2:0]        bitCnt_q, bitCnt_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              mb_q, mb_d;
  logic              miso_q, miso_d;
  logic [DATA_W-1:0] lastCmd_q, lastCmd_d;
  logic              cmdValid_q, cmdValid_d;
  logic              wrStrobe_q, wrStrobe_d;
  logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
  logic [DATA_W-1:0] wrData_q, wrData_d;
  logic              spiWrEn;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] rxByte;
  logic [ADDR_W-1:0] rdAddr;
  logic [DATA_W-1:0] rdData;

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sclk (
    .clk    (clk),
    .rst_n  (rst_n),
    .async_i(spi_clk),
    .level_o(unusedSclkLvl),
    .rise_o (sclkRise),
    .fall_o (sclkFall)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk    (clk),
    .rst_n  (rst_n),
    .async_i(CS),
    .level_o(csLvl),
    .rise_o (csRise),
    .fall_o (csFall)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk    (clk),
    .rst_n  (rst_n),
    .async_i(MOSI),
    .level_o(mosiLvl),
    .rise_o (unusedMosiRise),
    .fall_o (unusedMosiFall)
  );

  // The byte as it will look once the current MOSI bit is shifted in.
  assign rxByte = {rx_q[DATA_W-2:0], mosiLvl};

  // In CMD the read address comes straight from the command byte being
  // completed; in RD_DATA it is the next burst address.
  assign rdAddr = (state_q == CMD) ? rxByte[ADDR_W-1:0] : nextAddr(addr_q, mb_q);

  // Write-first read port: a host write landing this cycle is visible at once.
  assign rdData = (rdAddr == '0)                          ? DEVID      :
                  (host_wr_en && (host_addr == rdAddr))   ? host_wdata :
                                                            regs_q[rdAddr];

  // Transaction FSM: next state, shift registers, MISO and output pulses.
  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    addr_d     = addr_q;
    mb_d       = mb_q;
    miso_d     = miso_q;
    lastCmd_d  = lastCmd_q;
    cmdValid_d = 1'b0;
    wrStrobe_d = 1'b0;
    wrAddr_d   = wrAddr_q;
    wrData_d   = wrData_q;
    spiWrEn    = 1'b0;

    if (csRise) begin
      state_d  = IDLE;
      bitCnt_d = 3'd7;
      miso_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          miso_d = 1'b0;
          if (csFall) begin
            state_d  = CMD;
            bitCnt_d = 3'd7;
          end
        end

        CMD: begin
          miso_d = 1'b0;
          if (sclkRise) begin
            rx_d = rxByte;
            if (bitCnt_q == 3'd0) begin
              bitCnt_d   = 3'd7;
              lastCmd_d  = rxByte;
              cmdValid_d = 1'b1;
              addr_d     = rxByte[ADDR_W-1:0];
              mb_d       = rxByte[CMD_MB_BIT];
              if (rxByte[CMD_RW_BIT]) begin
                state_d = RD_DATA;
                tx_d    = rdData;
              end else begin
                state_d = WR_DATA;
              end
            end else begin
              bitCnt_d = bitCnt_q - 3'd1;
            end
          end
        end

        RD_DATA: begin
          if (sclkFall) begin
            miso_d = tx_q[DATA_W-1];
            tx_d   = {tx_q[DATA_W-2:0], 1'b0};
          end else if (sclkRise) begin
            if (bitCnt_q == 3'd0) begin
              bitCnt_d = 3'd7;
              addr_d   = nextAddr(addr_q, mb_q);
              tx_d     = rdData;
            end else begin
              bitCnt_d = bitCnt_q - 3'd1;
            end
          end
        end

        WR_DATA: begin
          if (sclkRise) begin
            rx_d = rxByte;
            if (bitCnt_q == 3'd0) begin
              bitCnt_d = 3'd7;
`ifdef SPI_SLAVE_WRITE_EN
              wrStrobe_d = 1'b1;
              wrAddr_d   = addr_q;
              wrData_d   = rxByte;
              spiWrEn    = (addr_q != '0);
`endif
              addr_d = nextAddr(addr_q, mb_q);
            end else begin
              bitCnt_d = bitCnt_q - 3'd1;
            end
          end
        end

        default: begin
          state_d = IDLE;
          miso_d  = 1'b0;
        end
      endcase
    end
  end

  // FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bitCnt_q   <= 3'd7;
      rx_q       <= '0;
      tx_q       <= '0;
      addr_q     <= '0;
      mb_q       <= 1'b0;
      miso_q     <= 1'b0;
      lastCmd_q  <= '0;
      cmdValid_q <= 1'b0;
      wrStrobe_q <= 1'b0;
      wrAddr_q   <= '0;
      wrData_q   <= '0;
    end else begin
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      addr_q     <= addr_d;
      mb_q       <= mb_d;
      miso_q     <= miso_d;
      lastCmd_q  <= lastCmd_d;
      cmdValid_q <= cmdValid_d;
      wrStrobe_q <= wrStrobe_d;
      wrAddr_q   <= wrAddr_d;
      wrData_q   <= wrData_d;
    end
  end

  // Register file: SPI write first, host write last so the host wins a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      if (spiWrEn) begin
        regs_q[addr_q] <= rxByte;
      end
      if (host_wr_en && (host_addr != '0)) begin
        regs_q[host_addr] <= host_wdata;
      end
    end
  end

  assign MISO      = miso_q;
  assign busy      = ~csLvl;
  assign wr_strobe = wrStrobe_q;
  assign wr_addr   = wrAddr_q;
  assign wr_data   = wrData_q;
  assign last_cmd  = lastCmd_q;
  assign cmd_valid = cmdValid_q;

endmodule

// File: tb/tb_spi_slave_regs.sv
// Directed testbench for spi_slave_regs. Covers both builds: with and
// without SPI_SLAVE_WRITE_EN defined.
module tb_spi_slave_regs;

  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 8;

  logic       clk;
  logic       rst_n;
  logic       spi_clk;
  logic       CS;
  logic       MOSI;
  logic       MISO;
  logic       host_wr_en;
  logic [5:0] host_addr;
  logic [7:0] host_wdata;
  logic       wr_strobe;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] last_cmd;
  logic       cmd_valid;
  logic       busy;

  int testsRun    = 0;
  int testsFailed = 0;
  int strobeCnt   = 0;
  int cmdCnt      = 0;

  spi_slave_regs #(
    .SYNC_STAGES(SYNC_STAGES),
    .DEVID      (8'hE5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi_clk   (spi_clk),
    .CS        (CS),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .host_wr_en(host_wr_en),
    .host_addr (host_addr),
    .host_wdata(host_wdata),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .last_cmd  (last_cmd),
    .cmd_valid (cmd_valid),
    .busy      (busy)
  );

  // 100 MHz system clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count single-cycle pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_strobe) strobeCnt++;
    if (cmd_valid) cmdCnt++;
  end

  // Safety net so the run always ends.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Mode-3 master: drive on falling edge, sample MISO just before rising edge.
  task automatic applyStimulus(input logic [7:0] txByte, input int nBits,
                               output logic [7:0] rxByte);
    rxByte = 8'h00;
    for (int i = 7; i > 7 - nBits; i--) begin
      spi_clk = 1'b0;
      MOSI    = txByte[i];
      repeat (HALF) @(negedge clk);
      rxByte[i] = MISO;
      spi_clk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
  endtask

  task automatic csLow();
    @(negedge clk);
    CS = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic csHigh();
    CS   = 1'b1;
    MOSI = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic hostWrite(input logic [5:0] addr, input logic [7:0] data);
    @(negedge clk);
    host_addr  = addr;
    host_wdata = data;
    host_wr_en = 1'b1;
    @(negedge clk);
    host_wr_en = 1'b0;
  endtask

  task automatic readTransfer(input logic [7:0] cmd, output logic [7:0] data);
    logic [7:0] dummy;
    csLow();
    applyStimulus(cmd, 8, dummy);
    applyStimulus(8'h00, 8, data);
    csHigh();
  endtask

  task automatic writeTransfer(input logic [7:0] cmd, input logic [7:0] data);
    logic [7:0] dummy;
    csLow();
    applyStimulus(cmd, 8, dummy);
    applyStimulus(data, 8, dummy);
    csHigh();
  endtask

  initial begin
    logic [7:0] rx;
    logic [7:0] rx2;
    logic [7:0] rx3;
    logic [7:0] dummy;
    int         base;

    rst_n      = 1'b0;
    spi_clk    = 1'b1;
    CS         = 1'b1;
    MOSI       = 1'b0;
    host_wr_en = 1'b0;
    host_addr  = 6'h00;
    host_wdata = 8'h00;
    repeat (5) @(negedge clk);

    checkOutput("reset_miso", MISO, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_wr_strobe", wr_strobe, 1'b0);
    checkOutput("reset_cmd_valid", cmd_valid, 1'b0);
    checkOutput("reset_last_cmd", last_cmd, 8'h00);
    checkOutput("reset_wr_addr", wr_addr, 6'h00);
    checkOutput("reset_wr_data", wr_data, 8'h00);

    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Read DEVID with one data byte.
    base = cmdCnt;
    csLow();
    checkOutput("busy_during_cs", busy, 1'b1);
    applyStimulus(8'h80, 8, dummy);
    applyStimulus(8'h00, 8, rx);
    checkOutput("devid_miso_last_bit", MISO, 1'b1);
    csHigh();
    checkOutput("devid_read", rx, 8'hE5);
    checkOutput("devid_cmd_valid_cnt", cmdCnt - base, 1);
    checkOutput("devid_last_cmd", last_cmd, 8'h80);
    checkOutput("miso_idle_after_cs", MISO, 1'b0);
    checkOutput("busy_idle_after_cs", busy, 1'b0);

    // Host writes to address 0 are ignored.
    hostWrite(6'h00, 8'h99);
    readTransfer(8'h80, rx);
    checkOutput("host_wr_addr0_ignored", rx, 8'hE5);

`ifdef SPI_SLAVE_WRITE_EN
    // Write then read back.
    base = strobeCnt;
    writeTransfer(8'h31, 8'hA5);
    checkOutput("wr31_strobe_cnt", strobeCnt - base, 1);
    checkOutput("wr31_wr_addr", wr_addr, 6'h31);
    checkOutput("wr31_wr_data", wr_data, 8'hA5);
    checkOutput("wr31_last_cmd", last_cmd, 8'h31);
    readTransfer(8'hB1, rx);
    checkOutput("rd31_data", rx, 8'hA5);
`else
    // Writes are disabled: no strobe, register stays cleared.
    base = strobeCnt;
    writeTransfer(8'h20, 8'h77);
    checkOutput("wr20_no_strobe", strobeCnt - base, 0);
    checkOutput("wr20_wr_addr_idle", wr_addr, 6'h00);
    checkOutput("wr20_last_cmd", last_cmd, 8'h20);
    readTransfer(8'hA0, rx);
    checkOutput("rd20_unchanged", rx, 8'h00);
`endif

    // Multi-byte read burst wrapping 0x3F -> 0x00 -> 0x01.
    hostWrite(6'h3F, 8'h11);
    hostWrite(6'h01, 8'h22);
    csLow();
    applyStimulus(8'hFF, 8, dummy);
    applyStimulus(8'h00, 8, rx);
    applyStimulus(8'h00, 8, rx2);
    applyStimulus(8'h00, 8, rx3);
    csHigh();
    checkOutput("burst_byte0_3F", rx, 8'h11);
    checkOutput("burst_byte1_00", rx2, 8'hE5);
    checkOutput("burst_byte2_01", rx3, 8'h22);

    // Abort a write after 4 data bits.
    hostWrite(6'h10, 8'h5A);
    base = strobeCnt;
    csLow();
    applyStimulus(8'h10, 8, dummy);
    applyStimulus(8'hFF, 4, dummy);
    CS = 1'b1;
    repeat (SYNC_STAGES + 1) @(posedge clk);
    #1;
    checkOutput("abort_wr_miso", MISO, 1'b0);
    repeat (HALF) @(negedge clk);
    checkOutput("abort_wr_no_strobe", strobeCnt - base, 0);
    readTransfer(8'h90, rx);
    checkOutput("abort_wr_reg_kept", rx, 8'h5A);

    // Abort a read mid-byte while MISO is driving a one.
    csLow();
    applyStimulus(8'h90, 8, dummy);
    applyStimulus(8'h00, 4, dummy);
    checkOutput("abort_rd_miso_before", MISO, 1'b1);
    CS = 1'b1;
    repeat (SYNC_STAGES + 1) @(posedge clk);
    #1;
    checkOutput("abort_rd_miso_after", MISO, 1'b0);
    repeat (HALF) @(negedge clk);

    // Write to address 0 with 0x00.
    base = strobeCnt;
    writeTransfer(8'h00, 8'h00);
`ifdef SPI_SLAVE_WRITE_EN
    checkOutput("wr00_strobe_cnt", strobeCnt - base, 1);
    checkOutput("wr00_wr_addr", wr_addr, 6'h00);
    checkOutput("wr00_wr_data", wr_data, 8'h00);
`else
    checkOutput("wr00_no_strobe", strobeCnt - base, 0);
`endif
    readTransfer(8'h80, rx);
    checkOutput("rd00_still_devid", rx, 8'hE5);

    // Reset in the middle of a read of 0x3F (0x11).
    csLow();
    applyStimulus(8'hBF, 8, dummy);
    applyStimulus(8'h00, 4, dummy);
    checkOutput("rst_rd_miso_before", MISO, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_rd_miso", MISO, 1'b0);
    checkOutput("rst_rd_busy", busy, 1'b0);
    checkOutput("rst_rd_last_cmd", last_cmd, 8'h00);
    CS      = 1'b1;
    spi_clk = 1'b1;
    MOSI    = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    readTransfer(8'hBF, rx);
    checkOutput("post_rst_reg3F_cleared", rx, 8'h00);
    readTransfer(8'h80, rx);
    checkOutput("post_rst_devid", rx, 8'hE5);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
